// File: rtl/vga_sync_gen_pkg.sv
// Shared VGA 640x480@60 timing defaults, line/frame total helper, colour-bar
// table and the bench clock period `T.
`ifndef T
`define T 10
`endif

package vga_sync_gen_pkg;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_SYNC_POL = 1'b0;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = vga_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = vga_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef logic [11:0] rgb12_t;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam rgb12_t BAR_COLORS [8] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel clock-enable: tick is high for one system clock out of every CLK_DIV.
module vga_pix_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // With CLK_DIV = 1 the counter never leaves 0, so tick stays high.
    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator with a built-in 8-bar colour test pattern.
// Optional macro VGA_FRAME_CNT_EN adds a 16-bit wrapping frame counter output.
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        rst,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic [11:0] rgb
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] BAR_W    = 10'(H_ACTIVE / 8);

    logic       tick;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_next, v_next;
    logic       h_wrap, v_wrap;
    logic       hsync_d, vsync_d, video_on_d;
    rgb12_t     rgb_d;
    logic [2:0] bar;

    vga_pix_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_next = h_cnt;
        v_next = v_cnt;
        if (tick) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                h_next = h_cnt + 1'b1;
            end
        end
    end

    // Outputs decode the next-state counters so the registered outputs line
    // up with the counters on the same edge.
    always_comb begin
        bar        = 3'(h_next / BAR_W);
        hsync_d    = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d    = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
        video_on_d = (h_next < H_VIS) && (v_next < V_VIS);
        rgb_d      = video_on_d ? BAR_COLORS[bar] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            hsync    <= ~SYNC_POL;
            vsync    <= ~SYNC_POL;
            video_on <= 1'b0;
            pixel_x  <= '0;
            pixel_y  <= '0;
            rgb      <= '0;
        end else begin
            h_cnt    <= h_next;
            v_cnt    <= v_next;
            hsync    <= hsync_d;
            vsync    <= vsync_d;
            video_on <= video_on_d;
            pixel_x  <= h_next;
            pixel_y  <= v_next;
            rgb      <= rgb_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (tick && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a full-size instance for line timing and
// colour bars, plus a shrunken CLK_DIV=1 instance for whole-frame behaviour.
module tb_vga_sync_gen;
    import vga_sync_gen_pkg::*;

    localparam int SH_A = 16, SH_FP = 2, SH_S = 3, SH_BP = 3;
    localparam int SV_A = 8,  SV_FP = 2, SV_S = 2, SV_BP = 3;
    localparam int S_FRAME = 24 * 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        hsync_m, vsync_m, video_on_m;
    logic [9:0]  pixel_x_m, pixel_y_m;
    logic [11:0] rgb_m;
    logic        hsync_s, vsync_s, video_on_s;
    logic [9:0]  pixel_x_s, pixel_y_s;
    logic [11:0] rgb_s;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_m, frame_cnt_s;
`endif

    always #(`T / 2) clk = ~clk;

    vga_sync_gen dut_m (
        .clk(clk), .rst(rst), .hsync(hsync_m), .vsync(vsync_m), .video_on(video_on_m),
        .pixel_x(pixel_x_m), .pixel_y(pixel_y_m), .rgb(rgb_m)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_m)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(SH_A), .H_FP(SH_FP), .H_SYNC(SH_S), .H_BP(SH_BP),
        .V_ACTIVE(SV_A), .V_FP(SV_FP), .V_SYNC(SV_S), .V_BP(SV_BP), .SYNC_POL(1'b1)
    ) dut_s (
        .clk(clk), .rst(rst), .hsync(hsync_s), .vsync(vsync_s), .video_on(video_on_s),
        .pixel_x(pixel_x_s), .pixel_y(pixel_y_s), .rgb(rgb_s)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(frame_cnt_s)
`endif
    );

    logic [34:0] obs_m, obs_s, exp_m, exp_s;
    logic [34:0] q_m[$];
    logic [34:0] q_s[$];
    int k = 0;
    int n_tests = 0;
    int n_fail = 0;
    int underflow = 0;

    assign obs_m = {hsync_m, vsync_m, video_on_m, pixel_x_m, pixel_y_m, rgb_m};
    assign obs_s = {hsync_s, vsync_s, video_on_s, pixel_x_s, pixel_y_s, rgb_s};

    function automatic logic [11:0] bar_colour(input int b);
        case (b)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // Closed-form raster model: k = clock edges since reset release (-1 = in reset).
    function automatic logic [34:0] model(input int kk, input int div,
                                          input int ha, input int hfp, input int hsw, input int hbp,
                                          input int va, input int vfp, input int vsw, input int vbp,
                                          input bit pol);
        int p, x, y, ht, vt;
        logic hs, vs, on;
        logic [11:0] c;
        if (kk < 0) return {~pol, ~pol, 1'b0, 10'd0, 10'd0, 12'd0};
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        p  = kk / div;
        x  = p % ht;
        y  = (p / ht) % vt;
        hs = (x >= ha + hfp && x < ha + hfp + hsw) ? pol : ~pol;
        vs = (y >= va + vfp && y < va + vfp + vsw) ? pol : ~pol;
        on = (x < ha) && (y < va);
        c  = on ? bar_colour(x / (ha / 8)) : 12'h000;
        return {hs, vs, on, 10'(x), 10'(y), c};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            k <= 0;
            q_m.push_back(model(-1, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            q_s.push_back(model(-1, 1, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, 1'b1));
        end else begin
            k <= k + 1;
            q_m.push_back(model(k + 1, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            q_s.push_back(model(k + 1, 1, SH_A, SH_FP, SH_S, SH_BP, SV_A, SV_FP, SV_S, SV_BP, 1'b1));
        end
    end

    always @(negedge clk) begin
        if (q_m.size() == 0 || q_s.size() == 0) begin
            underflow <= underflow + 1;
        end else begin
            exp_m <= q_m.pop_front();
            exp_s <= q_s.pop_front();
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) begin
            step();
            n_tests++;
            if (obs_m !== exp_m) begin n_fail++; $display("FAIL reset_sb_m got=%h want=%h", obs_m, exp_m); end
            n_tests++;
            if (obs_s !== exp_s) begin n_fail++; $display("FAIL reset_sb_s got=%h want=%h", obs_s, exp_s); end
        end
        n_tests++;
        if (obs_m !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0}) begin
            n_fail++; $display("FAIL reset_const_m got=%h", obs_m);
        end
    endtask

    task automatic test_release();
        int edges;
        rst = 1'b0;
        step();
        n_tests++;
        if ({video_on_m, rgb_m, pixel_x_m} !== {1'b1, 12'hFFF, 10'd0}) begin
            n_fail++; $display("FAIL release_first got von=%b rgb=%h x=%0d want 1 FFF 0", video_on_m, rgb_m, pixel_x_m);
        end
        n_tests++;
        if (obs_m !== exp_m) begin n_fail++; $display("FAIL release_sb got=%h want=%h", obs_m, exp_m); end
        edges = 1;
        while (pixel_x_m !== 10'd1 && edges < 20) begin
            step();
            edges++;
        end
        n_tests++;
        if (edges !== 4) begin n_fail++; $display("FAIL release_first_tick got=%0d want=4 clks", edges); end
    endtask

    task automatic test_colour_bars();
        int tx[5] = '{79, 80, 400, 639, 640};
        logic [11:0] tc[5] = '{12'hFFF, 12'hFF0, 12'hF00, 12'h000, 12'h000};
        int j = 0;
        for (int i = 0; i < 4000 && j < 5; i++) begin
            step();
            n_tests++;
            if (obs_m !== exp_m) begin n_fail++; $display("FAIL bars_sb got=%h want=%h", obs_m, exp_m); end
            if (pixel_x_m == 10'(tx[j])) begin
                n_tests++;
                if (rgb_m !== tc[j] || pixel_y_m !== 10'd0) begin
                    n_fail++; $display("FAIL bar_x%0d got rgb=%h y=%0d want %h y=0", tx[j], rgb_m, pixel_y_m, tc[j]);
                end
                j++;
            end
        end
        n_tests++;
        if (j !== 5) begin n_fail++; $display("FAIL bars_timeout got=%0d want=5 points", j); end
    endtask

    task automatic test_hline();
        logic [9:0] prev;
        bit found = 0;
        int hs_low = 0, von_low = 0, hs_min = 1023, hs_max = -1;
        prev = pixel_x_m;
        for (int i = 0; i < 4000 && !found; i++) begin
            step();
            if (pixel_x_m == 10'd0 && prev != 10'd0) found = 1;
            else prev = pixel_x_m;
        end
        n_tests++;
        if (!found || prev !== 10'd799) begin
            n_fail++; $display("FAIL hline_wrap got prev=%0d found=%0d want 799", prev, found);
        end
        for (int i = 0; i < DEF_H_TOTAL * 4; i++) begin
            if (i > 0) step();
            n_tests++;
            if (obs_m !== exp_m) begin n_fail++; $display("FAIL hline_sb got=%h want=%h", obs_m, exp_m); end
            if (hsync_m === 1'b0) begin
                hs_low++;
                if (int'(pixel_x_m) < hs_min) hs_min = int'(pixel_x_m);
                if (int'(pixel_x_m) > hs_max) hs_max = int'(pixel_x_m);
            end
            if (video_on_m === 1'b0) von_low++;
        end
        n_tests++;
        if (hs_low !== 384) begin n_fail++; $display("FAIL hsync_width got=%0d want=384", hs_low); end
        n_tests++;
        if (hs_min !== 656 || hs_max !== 751) begin
            n_fail++; $display("FAIL hsync_span got=%0d..%0d want=656..751", hs_min, hs_max);
        end
        n_tests++;
        if (von_low !== 640) begin n_fail++; $display("FAIL hblank_clks got=%0d want=640", von_low); end
        step();
        n_tests++;
        if (pixel_x_m !== 10'd0 || pixel_y_m !== 10'd2) begin
            n_fail++; $display("FAIL line_period got x=%0d y=%0d want 0 2", pixel_x_m, pixel_y_m);
        end
    endtask

    task automatic test_mid_reset();
        int i = 0;
        while (pixel_x_m !== 10'd300 && i < 4000) begin
            step();
            i++;
        end
        n_tests++;
        if (pixel_x_m !== 10'd300) begin n_fail++; $display("FAIL mid_wait got=%0d want=300", pixel_x_m); end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (obs_m !== {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 12'd0}) begin
            n_fail++; $display("FAIL mid_reset_async_m got=%h", obs_m);
        end
        n_tests++;
        if (obs_s !== {1'b0, 1'b0, 1'b0, 10'd0, 10'd0, 12'd0}) begin
            n_fail++; $display("FAIL mid_reset_async_s got=%h", obs_s);
        end
        repeat (5) begin
            step();
            n_tests++;
            if (obs_m !== exp_m) begin n_fail++; $display("FAIL mid_reset_sb got=%h want=%h", obs_m, exp_m); end
        end
        rst = 1'b0;
        step();
        n_tests++;
        if ({pixel_x_m, pixel_y_m, video_on_m, rgb_m} !== {10'd0, 10'd0, 1'b1, 12'hFFF}) begin
            n_fail++; $display("FAIL mid_restart got x=%0d y=%0d von=%b rgb=%h", pixel_x_m, pixel_y_m, video_on_m, rgb_m);
        end
    endtask

    task automatic test_vframe();
        int vs_act = 0, wraps = 0, first = -1, second = -1;
        logic [9:0] prev_y;
        prev_y = pixel_y_s;
        for (int i = 0; i < 3 * S_FRAME; i++) begin
            step();
            n_tests++;
            if (obs_s !== exp_s) begin n_fail++; $display("FAIL vframe_sb got=%h want=%h", obs_s, exp_s); end
            if (i < S_FRAME && vsync_s === 1'b1) vs_act++;
            if (prev_y == 10'd14 && pixel_y_s == 10'd0) wraps++;
            if (pixel_x_s == 10'd0 && pixel_y_s == 10'd0) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev_y = pixel_y_s;
        end
        n_tests++;
        if (vs_act !== 48) begin n_fail++; $display("FAIL vsync_width got=%0d want=48", vs_act); end
        n_tests++;
        if (wraps !== 3) begin n_fail++; $display("FAIL vwrap_count got=%0d want=3", wraps); end
        n_tests++;
        if (second - first !== S_FRAME) begin
            n_fail++; $display("FAIL frame_period got=%0d want=%0d", second - first, S_FRAME);
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt();
        rst = 1'b1;
        step();
        n_tests++;
        if (frame_cnt_m !== 16'd0 || frame_cnt_s !== 16'd0) begin
            n_fail++; $display("FAIL fcnt_reset got=%0d/%0d want=0", frame_cnt_m, frame_cnt_s);
        end
        repeat (4) step();
        rst = 1'b0;
        repeat (S_FRAME - 1) step();
        n_tests++;
        if (frame_cnt_s !== 16'd0) begin n_fail++; $display("FAIL fcnt_pre got=%0d want=0", frame_cnt_s); end
        step();
        n_tests++;
        if (frame_cnt_s !== 16'd1) begin n_fail++; $display("FAIL fcnt_second got=%0d want=1", frame_cnt_s); end
        repeat (S_FRAME) step();
        n_tests++;
        if (frame_cnt_s !== 16'd2) begin n_fail++; $display("FAIL fcnt_third got=%0d want=2", frame_cnt_s); end
    endtask
`endif

    initial begin
        #(`T * 60000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_release();
        test_colour_bars();
        test_hline();
        test_mid_reset();
        test_vframe();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt();
`endif
        n_tests++;
        if (underflow !== 0) begin n_fail++; $display("FAIL sb_underflow got=%0d want=0", underflow); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
